mv_stream_engine: RTL and testbench

//  Parametrised, sequential matrix-vector engine: y[M] = A[MxN] * x[N], signed fixed-point.
//  x is loaded once by handshake; A is streamed one row (N elements) per beat.

---
 rtl/mv_stream_engine_if.sv | 32 +++
 rtl/mv_stream_engine.sv | 130 +++++++++++++
 tb/tb_mv_stream_engine.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mv_stream_engine_if.sv
// Bundle of the three handshakes (x load, row stream, result) plus busy for
// mv_stream_engine. The engine connects through the slave modport.
//
// Handshake rule for all three channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds its data and
// valid stable until that edge; ready never depends combinationally on valid.
interface mv_stream_engine_if #(
   parameter int M  = 16,
   parameter int N  = 16,
   parameter int DW = 32
);
   logic [DW*N-1:0] vec_in;
   logic            vec_valid;
   logic            vec_ready;
   logic [DW*N-1:0] row_in;
   logic            row_valid;
   logic            row_ready;
   logic [DW*M-1:0] out_vec;
   logic            out_valid;
   logic            out_ready;
   logic            busy;

   modport master (
      output vec_in, vec_valid, row_in, row_valid, out_ready,
      input  vec_ready, row_ready, out_vec, out_valid, busy
   );

   modport slave (
      input  vec_in, vec_valid, row_in, row_valid, out_ready,
      output vec_ready, row_ready, out_vec, out_valid, busy
   );
endinterface

// File: rtl/mv_stream_engine.sv
// Sequential matrix-vector engine: y[M] = A[MxN] * x[N], signed fixed point.
// x is latched once, A arrives one row per accepted beat. Each row goes through
// a product stage and a sum/saturate stage before landing in its out_vec slot.
// Optional build macro: MV_RELU_EN -- clamp negative results to zero after
// saturation (timing unchanged).
module mv_stream_engine #(
   parameter int M     = 16,
   parameter int N     = 16,
   parameter int DW    = 32,
   parameter int ACC_W = 2*DW + $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   mv_stream_engine_if.slave bus,
   output logic [1:0]        dbg_state
);
   localparam int CW = (M > 1) ? $clog2(M) : 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROWS  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           row_cnt;
   logic [CW-1:0]           prod_row;
   logic                    prod_vld;
   logic signed [DW-1:0]    x_q    [N];
   logic signed [2*DW-1:0]  prod_q [N];
   logic signed [DW-1:0]    y_q    [M];
   logic signed [ACC_W-1:0] acc;
   logic signed [DW-1:0]    sat;
   logic signed [DW-1:0]    res;
   logic                    vec_fire;
   logic                    row_fire;

   assign vec_fire  = bus.vec_valid & bus.vec_ready;
   assign row_fire  = bus.row_valid & bus.row_ready;
   assign dbg_state = state;

   // State register; reset aborts any run immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake ready/valid outputs, all decoded from state only.
   always_comb begin
      state_nxt     = state;
      bus.vec_ready = 1'b0;
      bus.row_ready = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      unique case (state)
         IDLE: begin
            bus.vec_ready = 1'b1;
            bus.busy      = 1'b0;
            if (bus.vec_valid) state_nxt = ROWS;
         end
         ROWS: begin
            bus.row_ready = 1'b1;
            if (bus.row_valid && (row_cnt == CW'(M-1))) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // x register and row counter: x latched on load, counter steps per accepted row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt <= '0;
         x_q     <= '{default: '0};
      end else if (vec_fire) begin
         row_cnt <= '0;
         for (int j = 0; j < N; j++) x_q[j] <= bus.vec_in[j*DW +: DW];
      end else if (row_fire) begin
         row_cnt <= row_cnt + 1'b1;
      end
   end

   // Stage 1: full-width products of the accepted row, tagged with its row index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_vld <= 1'b0;
         prod_row <= '0;
         prod_q   <= '{default: '0};
      end else begin
         prod_vld <= row_fire;
         if (row_fire) begin
            prod_row <= row_cnt;
            for (int j = 0; j < N; j++)
               prod_q[j] <= (2*DW)'(x_q[j]) * (2*DW)'($signed(bus.row_in[j*DW +: DW]));
         end
      end
   end

   // Stage 2 datapath: sign-extended sum of the products, saturate to DW, optional ReLU.
   always_comb begin
      acc = '0;
      for (int j = 0; j < N; j++) acc = acc + ACC_W'(prod_q[j]);
      if (acc > SAT_MAX)      sat = {1'b0, {(DW-1){1'b1}}};
      else if (acc < SAT_MIN) sat = {1'b1, {(DW-1){1'b0}}};
      else                    sat = acc[DW-1:0];
`ifdef MV_RELU_EN
      res = sat[DW-1] ? '0 : sat;
`else
      res = sat;
`endif
   end

   // Result slots: only a valid stage-1 entry writes, so out_vec holds between runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        y_q <= '{default: '0};
      else if (prod_vld) y_q[prod_row] <= res;
   end

   for (genvar i = 0; i < M; i++) begin : g_pack
      assign bus.out_vec[i*DW +: DW] = y_q[i];
   end
endmodule

// File: tb/tb_mv_stream_engine.sv
// Bench for mv_stream_engine: a 4x4x16 instance for directed scenarios and a
// 16x16x32 instance for randomized runs, both checked against a wide-integer
// reference model of y = sat(A*x).
module tb_mv_stream_engine;
   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] s_dbg, b_dbg;
   int n_checks = 0;
   int n_fail   = 0;

   longint ga [16][16];
   longint gx [16];

   mv_stream_engine_if #(.M(4),  .N(4),  .DW(16)) sif ();
   mv_stream_engine_if #(.M(16), .N(16), .DW(32)) bif ();

   mv_stream_engine #(.M(4), .N(4), .DW(16)) u_small (
      .clk(clk), .rst_n(rst_n), .bus(sif.slave), .dbg_state(s_dbg)
   );
   mv_stream_engine #(.M(16), .N(16), .DW(32)) u_big (
      .clk(clk), .rst_n(rst_n), .bus(bif.slave), .dbg_state(b_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, longint obs, longint exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // reference model: exact dot product, clamp to signed dw, optional ReLU
   function automatic longint model(int dw, int n, int i);
      logic signed [127:0] s, p, maxv, minv;
      longint r;
      s = '0;
      for (int j = 0; j < n; j++) begin
         p = ga[i][j] * gx[j];
         s = s + p;
      end
      maxv = (128'sd1 <<< (dw-1)) - 128'sd1;
      minv = -(128'sd1 <<< (dw-1));
      if (s > maxv)      r = maxv[63:0];
      else if (s < minv) r = minv[63:0];
      else               r = s[63:0];
`ifdef MV_RELU_EN
      if (r < 0) r = 0;
`endif
      return r;
   endfunction

   function automatic longint rnd(int mode);
      case (mode)
         0: return longint'($signed($urandom()));
         1: return longint'($urandom_range(0, 2000)) - 1000;
         default: begin
            case ($urandom_range(0, 4))
               0:       return -64'sd2147483648;
               1:       return 64'sd2147483647;
               2:       return 0;
               3:       return 1;
               default: return -1;
            endcase
         end
      endcase
   endfunction

   // small-instance drivers
   task automatic s_send_x();
      int w = 0;
      for (int j = 0; j < 4; j++) sif.vec_in[j*16 +: 16] = gx[j][15:0];
      sif.vec_valid = 1'b1;
      while (!sif.vec_ready && w < 20) begin step(); w++; end
      if (w >= 20) check("s_vec_timeout", 0, 1);
      step();
      sif.vec_valid = 1'b0;
   endtask

   task automatic s_send_row(int i, int gap);
      int w = 0;
      for (int j = 0; j < 4; j++) sif.row_in[j*16 +: 16] = ga[i][j][15:0];
      sif.row_valid = 1'b1;
      while (!sif.row_ready && w < 20) begin step(); w++; end
      if (w >= 20) check("s_row_timeout", 0, 1);
      step();
      sif.row_valid = 1'b0;
      repeat (gap) step();
   endtask

   task automatic s_wait_out();
      int w = 0;
      while (!sif.out_valid && w < 20) begin step(); w++; end
      if (w >= 20) check("s_out_timeout", 0, 1);
   endtask

   task automatic s_check_out(string tag);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_y%0d", tag, i),
               longint'($signed(sif.out_vec[i*16 +: 16])), model(16, 4, i));
   endtask

   // full small run: rows with gaps, result held stall cycles before it is taken
   task automatic s_run(string tag, int gap, int stall);
      sif.out_ready = 1'b0;
      s_send_x();
      for (int i = 0; i < 4; i++) s_send_row(i, gap);
      s_wait_out();
      for (int c = 0; c < stall; c++) begin
         check($sformatf("%s_hold%0d", tag, c), sif.out_valid, 1);
         s_check_out($sformatf("%s_c%0d", tag, c));
         step();
      end
      check({tag, "_ov"}, sif.out_valid, 1);
      s_check_out(tag);
      sif.out_ready = 1'b1;
      step();
      sif.out_ready = 1'b0;
      check({tag, "_ov_drop"}, sif.out_valid, 0);
      check({tag, "_vec_ready"}, sif.vec_ready, 1);
   endtask

   // big-instance randomized run with stalls on every handshake
   task automatic b_run(int run);
      int w;
      int mode = run % 3;
      for (int j = 0; j < 16; j++) gx[j] = rnd(mode);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) ga[i][j] = rnd(mode);
      bif.out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      for (int j = 0; j < 16; j++) bif.vec_in[j*32 +: 32] = gx[j][31:0];
      bif.vec_valid = 1'b1;
      w = 0;
      while (!bif.vec_ready && w < 40) begin step(); w++; end
      if (w >= 40) check("b_vec_timeout", 0, 1);
      step();
      bif.vec_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 2)) step();
         for (int j = 0; j < 16; j++) bif.row_in[j*32 +: 32] = ga[i][j][31:0];
         bif.row_valid = 1'b1;
         w = 0;
         while (!bif.row_ready && w < 40) begin step(); w++; end
         if (w >= 40) check("b_row_timeout", 0, 1);
         step();
         bif.row_valid = 1'b0;
      end
      w = 0;
      while (!bif.out_valid && w < 40) begin step(); w++; end
      if (w >= 40) check("b_out_timeout", 0, 1);
      repeat ($urandom_range(0, 3)) step();
      check($sformatf("b%0d_ov", run), bif.out_valid, 1);
      for (int i = 0; i < 16; i++)
         check($sformatf("b%0d_y%0d", run, i),
               longint'($signed(bif.out_vec[i*32 +: 32])), model(32, 16, i));
      bif.out_ready = 1'b1;
      step();
      bif.out_ready = 1'b0;
      check($sformatf("b%0d_ov_drop", run), bif.out_valid, 0);
   endtask

   initial begin
      sif.vec_in = '0; sif.vec_valid = 1'b0; sif.row_in = '0; sif.row_valid = 1'b0; sif.out_ready = 1'b0;
      bif.vec_in = '0; bif.vec_valid = 1'b0; bif.row_in = '0; bif.row_valid = 1'b0; bif.out_ready = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) step();

      // reset state
      check("rst_vec_ready", sif.vec_ready, 1);
      check("rst_row_ready", sif.row_ready, 0);
      check("rst_out_valid", sif.out_valid, 0);
      check("rst_busy",      sif.busy, 0);
      check("rst_out_vec",   sif.out_vec, 0);
      check("rst_dbg_idle",  s_dbg, 0);
      check("rst_big_ready", bif.vec_ready, 1);
      check("rst_big_out",   longint'(bif.out_vec == '0), 1);
      check("rst_big_dbg",   b_dbg, 0);
      rst_n = 1'b1;
      step();

      // 1: identity A, back-to-back rows, out_valid exactly 2 cycles after last row
      for (int i = 0; i < 4; i++) begin
         gx[i] = i + 1;
         for (int j = 0; j < 4; j++) ga[i][j] = (i == j) ? 1 : 0;
      end
      sif.out_ready = 1'b1;
      s_send_x();
      check("t1_busy", sif.busy, 1);
      for (int i = 0; i < 4; i++) s_send_row(i, 0);
      check("t1_ov_k1", sif.out_valid, 0);
      check("t1_row_ready_k1", sif.row_ready, 0);
      step();
      check("t1_ov_k2", sif.out_valid, 1);
      s_check_out("t1");
      check("t1_y3_const", longint'($signed(sif.out_vec[48 +: 16])), 4);
      step();
      check("t1_ov_one_cycle", sif.out_valid, 0);
      check("t1_vec_ready", sif.vec_ready, 1);
      check("t1_busy_idle", sif.busy, 0);
      sif.out_ready = 1'b0;

      // 2: positive and negative saturation
      for (int i = 0; i < 4; i++) begin
         gx[i] = 32767;
         for (int j = 0; j < 4; j++) ga[i][j] = 32767;
      end
      s_run("t2_pos", 0, 0);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) ga[i][j] = -32768;
      s_run("t2_neg", 0, 0);

      // 3: gapped rows, result held under back-pressure, kept after leaving DONE
      for (int i = 0; i < 4; i++) begin
         gx[i] = 5 + i;
         ga[i][0] = i; ga[i][1] = -1; ga[i][2] = 2; ga[i][3] = 0;
      end
      s_run("t3", 1, 5);
      check("t3_y0_const",  longint'($signed(sif.out_vec[0  +: 16])), 8);
      check("t3_y3_retain", longint'($signed(sif.out_vec[48 +: 16])), 23);

      // 4: vec_valid during ROWS and row_valid during DONE are ignored
      for (int i = 0; i < 4; i++) begin
         gx[i] = 1;
         for (int j = 0; j < 4; j++) ga[i][j] = (j == 0) ? i + 1 : 3 * j - i;
      end
      s_send_x();
      s_send_row(0, 0);
      sif.vec_in = {4{16'd100}};
      sif.vec_valid = 1'b1;
      step();
      sif.vec_valid = 1'b0;
      check("t4_still_rows", sif.row_ready, 1);
      for (int i = 1; i < 4; i++) s_send_row(i, 0);
      s_wait_out();
      sif.row_in = {4{16'd50}};
      sif.row_valid = 1'b1;
      step();
      step();
      sif.row_valid = 1'b0;
      check("t4_ov_held", sif.out_valid, 1);
      s_check_out("t4");
      sif.out_ready = 1'b1;
      step();
      sif.out_ready = 1'b0;
      check("t4_idle", sif.vec_ready, 1);

      // 5: reset after two rows aborts, then a fresh run is correct
      for (int i = 0; i < 4; i++) begin
         gx[i] = longint'($urandom_range(0, 200)) - 100;
         for (int j = 0; j < 4; j++) ga[i][j] = longint'($urandom_range(0, 200)) - 100;
      end
      s_send_x();
      s_send_row(0, 0);
      s_send_row(1, 0);
      rst_n = 1'b0;
      #1;
      check("t5_ov",      sif.out_valid, 0);
      check("t5_ready",   sif.vec_ready, 1);
      check("t5_busy",    sif.busy, 0);
      check("t5_out_vec", sif.out_vec, 0);
      step();
      rst_n = 1'b1;
      step();
      s_run("t5_fresh", 0, 2);

      // 6: randomized full-size runs
      for (int r = 0; r < 100; r++) b_run(r);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
